servo_pwm_bank: RTL

Multi-channel servo PWM generator: drives CHANNELS independent hobby-servo outputs from one shared frame counter, converting a per-channel angle command (0–180°) into a pulse width in clock ticks. Commands arrive over a valid/ready write port, are latched per channel, and take effect only at frame boundaries, so pulses never glitch. It sits between the control logic and the PmodCON3 pins, replacing one counter/comparator pipeline per servo.

---
 rtl/servo_pwm_bank.sv | 98 +++++++++
 1 files changed

// File: rtl/servo_pwm_bank.sv
// Multi-channel hobby-servo PWM generator sharing one frame counter.
// Define SERVO_SLEW_EN to rate-limit width changes to SLEW_TICKS per frame.
module servo_pwm_bank #(
    parameter int CHANNELS   = 4,
    parameter int CLK_HZ     = 100_000_000,
    parameter int PERIOD_US  = 20000,
    parameter int MIN_US     = 1000,
    parameter int MAX_US     = 2000,
    parameter int SLEW_TICKS = 5555
) (
    input  logic                                                clk,
    input  logic                                                clr,
    input  logic                                                cmd_valid,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cmd_ch,
    input  logic [8:0]                                          cmd_angle,
    output logic                                                cmd_ready,
    input  logic [CHANNELS-1:0]                                 ch_en,
    output logic [CHANNELS-1:0]                                 pwm,
    output logic [CHANNELS-1:0]                                 busy,
    output logic                                                frame_tick
);

    localparam int TPU          = CLK_HZ / 1_000_000;
    localparam int PERIOD_TICKS = PERIOD_US * TPU;
    localparam int MIN_TICKS    = MIN_US * TPU;
    localparam int TPD          = ((MAX_US - MIN_US) * TPU) / 180;
    localparam int CENTER       = MIN_TICKS + 90 * TPD;
    localparam int CW           = $clog2(PERIOD_TICKS);

    typedef logic [CW-1:0] ticks_t;

    localparam ticks_t LAST     = ticks_t'(PERIOD_TICKS - 1);
    localparam ticks_t CENTER_T = ticks_t'(CENTER);

    ticks_t     count;
    ticks_t     cur    [CHANNELS];
    ticks_t     target [CHANNELS];
    ticks_t     cmd_width;
    logic [8:0] angle_c;
    logic       wrap;
    logic       accept;

`ifdef SERVO_SLEW_EN
    localparam ticks_t STEP = ticks_t'((SLEW_TICKS > PERIOD_TICKS - 1) ? PERIOD_TICKS - 1 : SLEW_TICKS);

    function automatic ticks_t slew_toward(input ticks_t c, input ticks_t t);
        if (t > c)
            return ((t - c) > STEP) ? c + STEP : t;
        else
            return ((c - t) > STEP) ? c - STEP : t;
    endfunction
`endif

    // Commands are refused on the wrap cycle so a target write never races the frame update.
    assign wrap      = (count == LAST);
    assign cmd_ready = !clr && !wrap;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        angle_c   = (cmd_angle > 9'd180) ? 9'd180 : cmd_angle;
        cmd_width = ticks_t'(MIN_TICKS + int'(angle_c) * TPD);
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < CHANNELS; i++)
            busy[i] = (cur[i] != target[i]);
    end

    // Only cur reaches the comparator, and it changes only on the wrap edge, so pulses cannot glitch.
    always_ff @(posedge clk) begin
        if (clr) begin
            count      <= '0;
            pwm        <= '0;
            frame_tick <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cur[i]    <= CENTER_T;
                target[i] <= CENTER_T;
            end
        end else begin
            count      <= wrap ? '0 : count + 1'b1;
            frame_tick <= (count == '0);
            for (int i = 0; i < CHANNELS; i++) begin
                pwm[i] <= ch_en[i] && (count < cur[i]);
                if (wrap) begin
`ifdef SERVO_SLEW_EN
                    cur[i] <= slew_toward(cur[i], target[i]);
`else
                    cur[i] <= target[i];
`endif
                end
                if (accept && (int'(cmd_ch) == i))
                    target[i] <= cmd_width;
            end
        end
    end

endmodule
